ker_sram_write: RTL and testbench
=================================

KER_SRAM_WRITE -- requirements
Module: ker_sram_write

Interface
REQ-001 SHALL have parameter DATA_W, default 64, FIFO word and SRAM data width.
REQ-002 SHALL have parameter ADDR_W, default 10, per-bank SRAM address width.
REQ-003 SHALL have parameter NUM_BANK, default 8, number of kernel SRAM banks (power of two).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request from master FSM.
REQ-007 SHALL have port cfg_words  input  ADDR_W+1  words per bank, sampled on accepted start.
REQ-008 SHALL have port ker_write_empty_n  input  1  FIFO has valid word.
REQ-009 SHALL have port ker_din  input  DATA_W  FIFO head word, valid while ker_write_empty_n=1.
REQ-010 SHALL have port ker_write_read  output  1  FIFO pop, combinational.
REQ-011 SHALL have port ker_write_busy  output  1  block owns the FIFO path.
REQ-012 SHALL have port ker_write_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port sram_we  output  NUM_BANK  one-hot bank write enable, active-high.
REQ-014 SHALL have port sram_addr  output  ADDR_W  write address, shared by all banks.
REQ-015 SHALL have port sram_wdata  output  DATA_W  write data, shared by all banks.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FIN.
REQ-017 IDLE: start=1 with cfg_words!=0 -> LOAD, latch cfg_words, clear word/bank counters; start with cfg_words=0 -> FIN (no FIFO read).
REQ-018 ker_write_read SHALL equal (state==LOAD) && ker_write_empty_n; a word is consumed in every cycle where ker_write_read=1.
REQ-019 Each consumed word SHALL be written one cycle later: sram_we one-hot at bank_cnt, sram_addr=word_cnt, sram_wdata=ker_din, all registered.
REQ-020 word_cnt SHALL increment per consumed word; at cfg_words-1 wrap to 0 and bank_cnt increments.
REQ-021 Consuming word cfg_words-1 of bank NUM_BANK-1 SHALL move LOAD -> FIN; total words = cfg_words*NUM_BANK.
REQ-022 FIN SHALL last one cycle, assert ker_write_done=1, coincide with final SRAM write, then -> IDLE.
REQ-023 ker_write_busy SHALL be 1 in LOAD and FIN, 0 in IDLE.
REQ-024 FIFO empty in LOAD SHALL stall: no read, no counter change, sram_we=0 next cycle.
REQ-025 start while busy SHALL be ignored (no restart, counters unaffected).
REQ-026 sram_we SHALL be all-zero in every cycle not following a consumed word.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counters 0, sram_we=0, sram_addr=0, sram_wdata=0, ker_write_done=0, ker_write_busy=0, ker_write_read=0, including mid-LOAD.
REQ-028 After release, first start SHALL behave as from power-up; partially written banks are not restored.

Configuration
REQ-029 Macro KER_WR_OVR_CHK_EN SHALL, when defined, add output ker_write_ovr (1 bit): set on start while busy, sticky, cleared by reset or next accepted start.
REQ-030 Without KER_WR_OVR_CHK_EN the port SHALL not exist and start-while-busy is silently ignored.

Structure
REQ-031 FSM state encoding (2-bit IDLE=0, LOAD=1, FIN=2) and default widths SHALL live in shared package ker_pkg with master FSM constants.
REQ-032 Word/bank counter pair SHALL be sub-module ker_addr_gen (enable, clear, cfg_words -> word_cnt, bank_cnt, last).

Verification
REQ-033 cfg_words=4, FIFO always full, start -> 32 reads on consecutive cycles, sram_we 0x01 addr 0..3 ... 0x80 addr 0..3, done in cycle of 32nd write.
REQ-034 cfg_words=2, empty_n toggling 1/0 -> reads only when empty_n=1, 16 writes total, no write in stall-following cycles.
REQ-035 cfg_words=0, start -> no read, busy=1 one cycle, done pulse next cycle, sram_we stays 0.
REQ-036 rst_n=0 after 10 words of cfg_words=4 -> all outputs 0 same cycle; new start writes bank 0 addr 0 first.
REQ-037 start pulse at word 5 of a load -> load completes unchanged at 32 words; with KER_WR_OVR_CHK_EN ker_write_ovr=1 until next accepted start.
REQ-038 cfg_words=1024 (max), full FIFO -> 8192 writes, addr wraps 1023->0 with bank increment, single done pulse.

Source files
------------

// File: rtl/ker_pkg.sv
// Shared kernel-path package: write FSM encoding, default widths
// and master FSM constants.
package ker_pkg;

   localparam int KER_DATA_W   = 64;
   localparam int KER_ADDR_W   = 10;
   localparam int KER_NUM_BANK = 8;

   typedef enum logic [1:0] {
      KER_IDLE = 2'd0,
      KER_LOAD = 2'd1,
      KER_FIN  = 2'd2
   } ker_wr_state_e;

   // Master FSM phases that sequence this block.
   localparam logic [2:0] MST_IDLE = 3'd0;
   localparam logic [2:0] MST_KER  = 3'd1;
   localparam logic [2:0] MST_IMG  = 3'd2;
   localparam logic [2:0] MST_RUN  = 3'd3;
   localparam logic [2:0] MST_DONE = 3'd4;

   function automatic int bank_w(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/ker_addr_gen.sv
// Word/bank counter pair for the kernel SRAM write path.
// Ports: en_i advance, clr_i clear, cfg_words_i words/bank -> word_cnt_o, bank_cnt_o, last_o.
module ker_addr_gen
   import ker_pkg::*;
#(
   parameter int ADDR_W   = KER_ADDR_W,
   parameter int NUM_BANK = KER_NUM_BANK,
   parameter int BANK_W   = bank_w(KER_NUM_BANK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [ADDR_W:0]   cfg_words_i,
   output logic [ADDR_W-1:0] word_cnt_o,
   output logic [BANK_W-1:0] bank_cnt_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] word_q, word_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic              wrap;
   logic [ADDR_W:0]   cfg_m1;

   assign cfg_m1 = cfg_words_i - {{ADDR_W{1'b0}}, 1'b1};
   assign wrap   = ({1'b0, word_q} == cfg_m1);
   assign last_o = wrap && (bank_q == BANK_W'(NUM_BANK - 1));

   assign word_cnt_o = word_q;
   assign bank_cnt_o = bank_q;

   always_comb begin
      word_d = word_q;
      bank_d = bank_q;
      if (clr_i) begin
         word_d = '0;
         bank_d = '0;
      end else if (en_i) begin
         if (wrap) begin
            word_d = '0;
            bank_d = bank_q + BANK_W'(1);
         end else begin
            word_d = word_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         bank_q <= '0;
      end else begin
         word_q <= word_d;
         bank_q <= bank_d;
      end
   end

endmodule

// File: rtl/ker_sram_write.sv
// Moves cfg_words*NUM_BANK kernel words from the FIFO into the banked SRAM.
// Ports: start/cfg_words in, FIFO pop/head, busy/done, one-hot sram_we/addr/wdata.
// Optional KER_WR_OVR_CHK_EN adds sticky ker_write_ovr (start while busy).
module ker_sram_write
   import ker_pkg::*;
#(
   parameter int DATA_W   = KER_DATA_W,
   parameter int ADDR_W   = KER_ADDR_W,
   parameter int NUM_BANK = KER_NUM_BANK
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W:0]     cfg_words,
   input  logic                ker_write_empty_n,
   input  logic [DATA_W-1:0]   ker_din,
   output logic                ker_write_read,
   output logic                ker_write_busy,
   output logic                ker_write_done,
`ifdef KER_WR_OVR_CHK_EN
   output logic                ker_write_ovr,
`endif
   output logic [NUM_BANK-1:0] sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata
);

   localparam int BANK_W = bank_w(NUM_BANK);

   ker_wr_state_e state_q, state_d;

   logic [ADDR_W:0]     cfg_q, cfg_d;
   logic [NUM_BANK-1:0] we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic [ADDR_W-1:0] word_cnt;
   logic [BANK_W-1:0] bank_cnt;
   logic              last;
   logic              acc_start;
   logic              rd;

   assign acc_start = start && (state_q == KER_IDLE);

   ker_addr_gen #(
      .ADDR_W   (ADDR_W),
      .NUM_BANK (NUM_BANK),
      .BANK_W   (BANK_W)
   ) u_addr (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (rd),
      .clr_i       (acc_start),
      .cfg_words_i (cfg_q),
      .word_cnt_o  (word_cnt),
      .bank_cnt_o  (bank_cnt),
      .last_o      (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= KER_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         KER_IDLE: begin
            if (start) begin
               state_d = (cfg_words == '0) ? KER_FIN : KER_LOAD;
            end
         end
         KER_LOAD: begin
            if (rd && last) state_d = KER_FIN;
         end
         KER_FIN:  state_d = KER_IDLE;
         default:  state_d = KER_IDLE;
      endcase
   end

   always_comb begin
      rd             = (state_q == KER_LOAD) && ker_write_empty_n;
      ker_write_busy = (state_q != KER_IDLE);
      ker_write_done = (state_q == KER_FIN);
   end

   assign ker_write_read = rd;

   // Write port lags the pop by one cycle; addr/data hold when idle.
   always_comb begin
      cfg_d   = acc_start ? cfg_words : cfg_q;
      we_d    = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (rd) begin
         we_d    = NUM_BANK'(1) << bank_cnt;
         addr_d  = word_cnt;
         wdata_d = ker_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q   <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         cfg_q   <= cfg_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign sram_we    = we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

`ifdef KER_WR_OVR_CHK_EN
   logic ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (acc_start)                  ovr_d = 1'b0;
      else if (start && ker_write_busy) ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovr_q <= 1'b0;
      else        ovr_q <= ovr_d;
   end

   assign ker_write_ovr = ovr_q;
`endif

endmodule

// File: tb/tb_ker_sram_write.sv
// Directed/random bench for ker_sram_write against a counting model.
// Model tracks only words consumed; bank/addr come from k/cfg and k%cfg.
module tb_ker_sram_write;

   localparam int DW = 64;
   localparam int AW = 10;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   cfg_words;
   logic          empty_n;
   logic [DW-1:0] din;
   logic          rd;
   logic          busy;
   logic          done;
   logic [NB-1:0] we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
`ifdef KER_WR_OVR_CHK_EN
   logic          ovr;
`endif

   always #5 clk = ~clk;

   ker_sram_write dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .cfg_words         (cfg_words),
      .ker_write_empty_n (empty_n),
      .ker_din           (din),
      .ker_write_read    (rd),
      .ker_write_busy    (busy),
      .ker_write_done    (done),
`ifdef KER_WR_OVR_CHK_EN
      .ker_write_ovr     (ovr),
`endif
      .sram_we           (we),
      .sram_addr         (addr),
      .sram_wdata        (wdata)
   );

   int vectors = 0;
   int errors  = 0;

   // reference model
   bit            m_loading;
   bit            m_busy;
   bit            m_done;
   int            m_k;
   int            m_total;
   int            m_cfg;
   logic [NB-1:0] m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            m_ovr;
   int            done_cnt;
   bit            tog;
   int            mode;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0; m_busy = 0; m_done = 0;
      m_k = 0; m_total = 0; m_cfg = 0;
      m_we = '0; m_addr = '0; m_data = '0; m_ovr = 0;
   endtask

   // mode: 0..100 = percent full, -1 = toggle 1/0
   task automatic cycle(input bit s, input int c);
      bit e;
      bit er;
      bit nd;
      @(negedge clk);
      start     = s;
      cfg_words = (AW+1)'(c);
      if (mode < 0) begin
         tog = ~tog;
         e   = tog;
      end else begin
         e = ($urandom_range(0, 99) < mode);
      end
      empty_n = e;
      din     = {$urandom, $urandom};
      #1;
      er = m_loading && e;
      chk("read", {63'd0, rd}, {63'd0, er});
      @(posedge clk);
      nd   = 0;
      m_we = '0;
      if (er) begin
         m_we   = NB'(1) << (m_k / m_cfg);
         m_addr = AW'(m_k % m_cfg);
         m_data = din;
         m_k++;
         if (m_k == m_total) begin
            m_loading = 0;
            nd = 1;
         end
      end else if (s && !m_busy) begin
         m_ovr = 0;
         if (c == 0) begin
            nd = 1;
         end else begin
            m_loading = 1;
            m_k = 0;
            m_cfg = c;
            m_total = c * NB;
         end
      end
      if (s && m_busy) m_ovr = 1;
      m_done = nd;
      m_busy = m_loading || nd;
      #1;
      chk("we", {56'd0, we}, {56'd0, m_we});
      chk("addr", {54'd0, addr}, {54'd0, m_addr});
      chk("wdata", wdata, m_data);
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
`ifdef KER_WR_OVR_CHK_EN
      chk("ovr", {63'd0, ovr}, {63'd0, m_ovr});
`endif
      if (done) done_cnt++;
   endtask

   task automatic run(input int c, input int inj_at, input int stop_at);
      int n;
      done_cnt = 0;
      cycle(1'b1, c);
      n = 0;
      while (m_busy && n < 20000 && !(stop_at >= 0 && m_k == stop_at)) begin
         cycle(inj_at >= 0 && m_k == inj_at, 5);
         n++;
      end
      if (n >= 20000) chk("timeout", 64'd1, 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4);
   endtask

   initial begin
      rst_n = 1'b0; start = 0; cfg_words = '0; empty_n = 0; din = '0;
      tog = 0; mode = 100;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", {56'd0, we}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // cfg=4, FIFO always full: 32 back-to-back writes
      mode = 100;
      run(4, -1, -1);
      idle(1);
      chk("done_cnt4", 64'(done_cnt), 64'd1);
      chk("words4", 64'(m_k), 64'd32);

      // cfg=2, toggling FIFO
      mode = -1;
      run(2, -1, -1);
      idle(2);
      chk("words2", 64'(m_k), 64'd16);

      // cfg=0: no reads, one-cycle FIN
      mode = 100;
      done_cnt = 0;
      cycle(1'b1, 0);
      idle(2);
      chk("done_cnt0", 64'(done_cnt), 64'd1);

      // random FIFO, odd cfg
      mode = 60;
      run(3, -1, -1);
      idle(2);

      // start while busy at word 5 is ignored
      mode = 100;
      run(4, 5, -1);
      idle(1);
      chk("words_inj", 64'(m_k), 64'd32);
`ifdef KER_WR_OVR_CHK_EN
      chk("ovr_sticky", {63'd0, ovr}, 64'd1);
`endif

      // reset mid-load after 10 words
      run(4, -1, 10);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mrst_we", {56'd0, we}, 64'd0);
      chk("mrst_addr", {54'd0, addr}, 64'd0);
      chk("mrst_wdata", wdata, 64'd0);
      chk("mrst_busy", {63'd0, busy}, 64'd0);
      chk("mrst_done", {63'd0, done}, 64'd0);
      chk("mrst_read", {63'd0, rd}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      run(4, -1, -1);
      idle(1);

      // maximum size: 1024 words per bank
      mode = 100;
      run(1024, -1, -1);
      idle(1);
      chk("done_cnt_max", 64'(done_cnt), 64'd1);
      chk("words_max", 64'(m_k), 64'd8192);

      mode = 50;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
